// File: rtl/dcache_assoc.sv
// N-way set-associative write-back, write-allocate data cache with
// age-based LRU replacement and saturating hit/miss counters.
module dcache_assoc #(
   parameter int WAYS       = 2,
   parameter int SETS       = 32,
   parameter int LINE_BYTES = 32,
   parameter int ADDR_W     = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [8*LINE_BYTES-1:0] mem_data_i,
   input  logic                    mem_ack_i,
   output logic [8*LINE_BYTES-1:0] mem_data_o,
   output logic [ADDR_W-1:0]       mem_addr_o,
   output logic                    mem_enable_o,
   output logic                    mem_write_o,
   input  logic [31:0]             p1_data_i,
   input  logic [ADDR_W-1:0]       p1_addr_i,
   input  logic                    p1_MemRead_i,
   input  logic                    p1_MemWrite_i,
   output logic [31:0]             p1_data_o,
   output logic                    p1_stall_o,
   output logic [31:0]             hit_cnt_o,
   output logic [31:0]             miss_cnt_o
);

   localparam int OFF_W  = $clog2(LINE_BYTES);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
   localparam int LW     = 8 * LINE_BYTES;
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int WSEL_W = OFF_W - 2;

   typedef enum logic [2:0] {
      IDLE,
      MISS,
      WRITEBACK,
      READMISS,
      READMISSOK
   } state_t;

   logic [LW-1:0]    line_q  [WAYS][SETS];
   logic [TAG_W-1:0] tag_q   [WAYS][SETS];
   logic             valid_q [WAYS][SETS];
   logic             dirty_q [WAYS][SETS];
   logic [WAY_W-1:0] age_q   [WAYS][SETS];

   state_t           state_q;
   state_t           state_d;
   logic [WAY_W-1:0] vic_q;
   logic [WAY_W-1:0] vic_d;
   logic [WAY_W-1:0] hit_way;
   logic [WAY_W-1:0] touch_way;
   logic             any_match;
   logic             req;
   logic             hit;
   logic             fill;
   logic             touch;
   logic             miss_start;
   logic             unused_addr_bits;

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [WSEL_W-1:0] wsel;

   assign idx  = p1_addr_i[OFF_W +: IDX_W];
   assign tag  = p1_addr_i[OFF_W+IDX_W +: TAG_W];
   assign wsel = p1_addr_i[2 +: WSEL_W];
   assign unused_addr_bits = ^p1_addr_i[1:0];

   assign req        = p1_MemRead_i | p1_MemWrite_i;
   assign hit        = (state_q == IDLE) & req & any_match;
   assign p1_stall_o = req & ~hit;
   assign fill       = (state_q == READMISS) & mem_ack_i;
   assign touch      = hit | fill;
   assign touch_way  = hit ? hit_way : vic_q;
   assign miss_start = (state_q == IDLE) & (state_d == MISS);

   always_comb begin
      any_match = 1'b0;
      hit_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
            any_match = 1'b1;
            hit_way   = WAY_W'(w);
         end
      end
   end

   // Oldest way by default; any invalid way (lowest index) takes priority.
   always_comb begin
      vic_d = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (age_q[w][idx] == WAY_W'(WAYS - 1)) vic_d = WAY_W'(w);
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[w][idx]) vic_d = WAY_W'(w);
      end
   end

   always_comb begin
      p1_data_o = '0;
      if (hit) p1_data_o = line_q[hit_way][idx][{wsel, 5'd0} +: 32];
   end

   always_comb begin
      state_d      = state_q;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      unique case (state_q)
         IDLE: begin
            if (req && !any_match) state_d = MISS;
         end
         MISS: begin
            if (valid_q[vic_q][idx] && dirty_q[vic_q][idx]) state_d = WRITEBACK;
            else state_d = READMISS;
         end
         WRITEBACK: begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {tag_q[vic_q][idx], idx, {OFF_W{1'b0}}};
            mem_data_o   = line_q[vic_q][idx];
            if (mem_ack_i) state_d = READMISS;
         end
         READMISS: begin
            mem_enable_o = 1'b1;
            mem_addr_o   = {tag, idx, {OFF_W{1'b0}}};
            if (mem_ack_i) state_d = READMISSOK;
         end
         READMISSOK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         vic_q   <= '0;
      end else begin
         state_q <= state_d;
         if (miss_start) vic_q <= vic_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int w = 0; w < WAYS; w++) begin
            for (int s = 0; s < SETS; s++) begin
               valid_q[w][s] <= 1'b0;
               dirty_q[w][s] <= 1'b0;
               age_q[w][s]   <= WAY_W'(w);
            end
         end
      end else begin
         if (fill) begin
            valid_q[vic_q][idx] <= 1'b1;
            dirty_q[vic_q][idx] <= 1'b0;
         end
         if (hit && p1_MemWrite_i) dirty_q[hit_way][idx] <= 1'b1;
         // Touched way becomes youngest; only ways younger than it age.
         if (touch) begin
            for (int w = 0; w < WAYS; w++) begin
               if (WAY_W'(w) == touch_way) begin
                  age_q[w][idx] <= '0;
               end else if (age_q[w][idx] < age_q[touch_way][idx]) begin
                  age_q[w][idx] <= age_q[w][idx] + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (fill) begin
         line_q[vic_q][idx] <= mem_data_i;
         tag_q[vic_q][idx]  <= tag;
      end
      if (hit && p1_MemWrite_i) begin
         line_q[hit_way][idx][{wsel, 5'd0} +: 32] <= p1_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
      end else begin
         if (hit && hit_cnt_o != 32'hFFFF_FFFF) hit_cnt_o <= hit_cnt_o + 32'd1;
         if (miss_start && miss_cnt_o != 32'hFFFF_FFFF) begin
            miss_cnt_o <= miss_cnt_o + 32'd1;
         end
      end
   end

endmodule
